// File: rtl/msk_sym_sampler.sv
// MSK symbol-timing sampler: integrates |I|+|Q| per sampling phase, picks the strongest
// phase by argmax scan, then decimates I/Q to symbol rate at that phase.
module msk_sym_sampler #(
    parameter int unsigned SPS      = 8,
    parameter int unsigned ACQ_SYMS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [15:0]     i_in,
    input  logic signed [15:0]     q_in,
    input  logic                   iq_val_i,
    input  logic                   reacq_i,
    output logic signed [15:0]     i_sym,
    output logic signed [15:0]     q_sym,
    output logic                   bit_i,
    output logic                   bit_q,
    output logic                   sym_val_o,
    output logic [$clog2(SPS)-1:0] phase_o,
    output logic                   lock_o
);

    localparam int unsigned PW = $clog2(SPS);
    localparam int unsigned SW = $clog2(ACQ_SYMS);
    localparam int unsigned AW = 17 + SW;
    localparam logic [PW-1:0] PhLast  = PW'(SPS - 1);
    localparam logic [SW-1:0] SymLast = SW'(ACQ_SYMS - 1);

    typedef enum logic [1:0] {StAcq, StSearch, StTrack} state_e;

    state_e               state_q, state_d;
    logic [1:0]           rst_sync_q;
    logic                 rst_sync_n;
    logic [PW-1:0]        ph_q;
    logic [SW-1:0]        sym_cnt_q;
    logic [AW-1:0]        acc_q [SPS];
    logic [PW-1:0]        scan_q;
    logic [AW-1:0]        best_val_q;
    logic [PW-1:0]        best_idx_q;
    logic [PW-1:0]        best_idx_d;
    logic [PW-1:0]        phase_q;
    logic                 lock_q;
    logic signed [15:0]   i_sym_q, q_sym_q;
    logic                 bit_i_q, bit_q_q, sym_val_q;
    logic [16:0]          mag;
    logic [AW-1:0]        cand;
    logic                 better;
    logic                 ph_last;
    logic                 acq_done;
    logic                 scan_last;
    logic                 capture;

    // |x| with -32768 clamped to 32767 so the result always fits 15 bits.
    function automatic logic [14:0] abs_sat(input logic signed [15:0] x);
        logic [15:0] neg;
        neg = 16'(-x);
        if (x == 16'sh8000) begin
            return 15'h7fff;
        end
        return x[15] ? neg[14:0] : x[14:0];
    endfunction

    // Assertion is immediate; release is retimed through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    assign mag       = {2'b00, abs_sat(i_in)} + {2'b00, abs_sat(q_in)};
    assign ph_last   = (ph_q == PhLast);
    assign acq_done  = (state_q == StAcq) && iq_val_i && ph_last && (sym_cnt_q == SymLast);
    assign scan_last = (scan_q == PhLast);
    assign capture   = (state_q == StTrack) && iq_val_i && (ph_q == phase_q);

    always_comb begin
        cand       = acc_q[scan_q];
        better     = cand > best_val_q;
        best_idx_d = better ? scan_q : best_idx_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StAcq:    if (acq_done)  state_d = StSearch;
            StSearch: if (scan_last) state_d = StTrack;
            StTrack:  state_d = StTrack;
            default:  state_d = StAcq;
        endcase
        if (reacq_i) begin
            state_d = StAcq;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= StAcq;
            lock_q  <= 1'b0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= (state_d == StTrack);
            if (iq_val_i) begin
                ph_q <= ph_last ? '0 : ph_q + PW'(1);
            end
        end
    end

    // Phase energy integration; a reacq request clears it even if it coincides with completion.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sym_cnt_q <= '0;
            for (int unsigned k = 0; k < SPS; k++) begin
                acc_q[k] <= '0;
            end
        end else if (reacq_i) begin
            sym_cnt_q <= '0;
            for (int unsigned k = 0; k < SPS; k++) begin
                acc_q[k] <= '0;
            end
        end else if (state_q == StAcq && iq_val_i) begin
            acc_q[ph_q] <= acc_q[ph_q] + AW'(mag);
            if (ph_last) begin
                sym_cnt_q <= sym_cnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            scan_q     <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            phase_q    <= '0;
        end else begin
            if (state_q != StSearch) begin
                scan_q     <= '0;
                best_val_q <= '0;
                best_idx_q <= '0;
            end else begin
                scan_q     <= scan_q + PW'(1);
                best_idx_q <= best_idx_d;
                if (better) begin
                    best_val_q <= cand;
                end
            end
            if (state_q == StSearch && state_d == StTrack) begin
                phase_q <= best_idx_d;
            end
        end
    end

    // Capture depends on the current state, so a sample taken in a reacq cycle still emits.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            i_sym_q   <= '0;
            q_sym_q   <= '0;
            bit_i_q   <= 1'b0;
            bit_q_q   <= 1'b0;
            sym_val_q <= 1'b0;
        end else begin
            sym_val_q <= capture;
            if (capture) begin
                i_sym_q <= i_in;
                q_sym_q <= q_in;
                bit_i_q <= ~i_in[15];
                bit_q_q <= ~q_in[15];
            end
        end
    end

    assign i_sym     = i_sym_q;
    assign q_sym     = q_sym_q;
    assign bit_i     = bit_i_q;
    assign bit_q     = bit_q_q;
    assign sym_val_o = sym_val_q;
    assign phase_o   = phase_q;
    assign lock_o    = lock_q;

endmodule

// File: tb/tb_msk_sym_sampler.sv
// Directed bench for msk_sym_sampler (SPS=8, ACQ_SYMS=4): acquisition, tie, saturation,
// gapped input, reacquisition and asynchronous reset.
module tb_msk_sym_sampler;

    localparam int SPS = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic               iq_val_i = 1'b0;
    logic               reacq_i = 1'b0;
    logic signed [15:0] i_sym, q_sym;
    logic               bit_i, bit_q, sym_val_o, lock_o;
    logic [2:0]         phase_o;

    msk_sym_sampler #(
        .SPS      (8),
        .ACQ_SYMS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_in      (i_in),
        .q_in      (q_in),
        .iq_val_i  (iq_val_i),
        .reacq_i   (reacq_i),
        .i_sym     (i_sym),
        .q_sym     (q_sym),
        .bit_i     (bit_i),
        .bit_q     (bit_q),
        .sym_val_o (sym_val_o),
        .phase_o   (phase_o),
        .lock_o    (lock_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int                 tb_ph = 0;
    int                 peak_ph = 3;
    logic signed [15:0] peak_i = 16'sd1000;
    logic signed [15:0] peak_q = 16'sd1000;
    int                 tie_ph = -1;
    logic signed [15:0] tie_i = '0;
    bit                 gapped = 1'b0;
    bit                 next_val = 1'b1;
    bit                 pend_reacq = 1'b0;
    bit                 last_val;
    int                 last_ph;
    logic signed [15:0] last_i, last_q;

    task automatic step(input bit idle);
        @(negedge clk);
        iq_val_i = idle ? 1'b0 : next_val;
        reacq_i  = pend_reacq;
        if (tb_ph == peak_ph) begin
            i_in = peak_i;
            q_in = peak_q;
        end else if (tb_ph == tie_ph) begin
            i_in = tie_i;
            q_in = '0;
        end else begin
            i_in = '0;
            q_in = '0;
        end
        last_val = iq_val_i;
        last_ph  = tb_ph;
        last_i   = i_in;
        last_q   = q_in;
        @(posedge clk);
        #1;
        reacq_i    = 1'b0;
        pend_reacq = 1'b0;
        if (last_val) tb_ph = (tb_ph + 1) % SPS;
        if (!idle) next_val = gapped ? !next_val : 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        tb_ph    = 0;
        next_val = 1'b1;
        repeat (3) step(1'b1);
    endtask

    // Runs until the 4th ph=7 sample after ACQ entry, then the 8 SEARCH cycles.
    task automatic run_acq(input int exp_phase, output int acq_cycles);
        int n7 = 0;
        int steps = 0;
        int bad_sv = 0;
        int bad_lk = 0;
        while (n7 < 4 && steps < 400) begin
            step(1'b0);
            steps++;
            if (last_val && last_ph == 7) n7++;
            if (sym_val_o !== 1'b0) bad_sv++;
            if (lock_o !== 1'b0) bad_lk++;
        end
        acq_cycles = steps;
        total++;
        if (n7 != 4) begin
            bad++;
            $display("FAIL acq_timeout: symbols=%0d required=4", n7);
        end
        for (int k = 0; k < 7; k++) begin
            step(1'b0);
            if (sym_val_o !== 1'b0) bad_sv++;
            if (lock_o !== 1'b0) bad_lk++;
        end
        step(1'b0);
        total++;
        if (lock_o !== 1'b1) begin
            bad++;
            $display("FAIL lock_rise: lock_o=%b required=1", lock_o);
        end
        total++;
        if (phase_o !== 3'(exp_phase)) begin
            bad++;
            $display("FAIL phase: phase_o=%0d required=%0d", phase_o, exp_phase);
        end
        total++;
        if (bad_sv != 0) begin
            bad++;
            $display("FAIL sym_val_in_acq: pulses=%0d required=0", bad_sv);
        end
        total++;
        if (bad_lk != 0) begin
            bad++;
            $display("FAIL early_lock: cycles=%0d required=0", bad_lk);
        end
    endtask

    task automatic track_steps(input int n, input int exp_phase, input int spacing);
        int prev = -1;
        bit have = 1'b0;
        bit exp_sv;
        logic signed [15:0] ei, eq;
        for (int s = 0; s < n; s++) begin
            step(1'b0);
            exp_sv = last_val && (last_ph == exp_phase);
            total++;
            if (sym_val_o !== exp_sv || lock_o !== 1'b1) begin
                bad++;
                $display("FAIL track_pulse step %0d: sym_val=%b lock=%b required sym_val=%b lock=1",
                         s, sym_val_o, lock_o, exp_sv);
            end
            if (exp_sv) begin
                have = 1'b1;
                ei   = last_i;
                eq   = last_q;
                if (prev >= 0) begin
                    total++;
                    if (s - prev != spacing) begin
                        bad++;
                        $display("FAIL spacing: got %0d required %0d", s - prev, spacing);
                    end
                end
                prev = s;
            end
            if (have) begin
                total++;
                if (i_sym !== ei || q_sym !== eq || bit_i !== ~ei[15] || bit_q !== ~eq[15]) begin
                    bad++;
                    $display("FAIL sym_data step %0d: i=%0d q=%0d bi=%b bq=%b required i=%0d q=%0d bi=%b bq=%b",
                             s, i_sym, q_sym, bit_i, bit_q, ei, eq, ~ei[15], ~eq[15]);
                end
            end
        end
        total++;
        if (prev < 0) begin
            bad++;
            $display("FAIL no_pulses: got 0 required >0");
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({lock_o, phase_o, sym_val_o, bit_i, bit_q} !== 6'b0 || i_sym !== 16'sd0 || q_sym !== 16'sd0) begin
            bad++;
            $display("FAIL reset_hold: lock=%b phase=%0d sv=%b i=%0d q=%0d required all 0",
                     lock_o, phase_o, sym_val_o, i_sym, q_sym);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        tb_ph    = 0;
        next_val = 1'b1;
        repeat (3) step(1'b1);
        total++;
        if (lock_o !== 1'b0 || phase_o !== 3'd0 || sym_val_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: lock=%b phase=%0d sv=%b required 0", lock_o, phase_o, sym_val_o);
        end
    endtask

    task automatic test_impulse();
        int c;
        peak_ph = 3; peak_i = 16'sd1000; peak_q = 16'sd1000; tie_ph = -1;
        run_acq(3, c);
        total++;
        if (c != 32) begin
            bad++;
            $display("FAIL impulse_acq_cycles: got %0d required 32", c);
        end
        track_steps(32, 3, 8);
    endtask

    task automatic test_tie();
        int c;
        do_reset();
        peak_ph = 2; peak_i = 16'sd500; peak_q = 16'sd0;
        tie_ph = 5; tie_i = 16'sd500;
        run_acq(2, c);
        track_steps(16, 2, 8);
        tie_ph = -1;
    endtask

    task automatic test_saturation();
        int c;
        do_reset();
        peak_ph = 6; peak_i = 16'sh8000; peak_q = 16'sh8000;
        run_acq(6, c);
        track_steps(16, 6, 8);
    endtask

    task automatic test_gapped();
        int c;
        do_reset();
        gapped  = 1'b1;
        peak_ph = 1; peak_i = 16'sd800; peak_q = -16'sd300;
        run_acq(1, c);
        total++;
        if (c != 63) begin
            bad++;
            $display("FAIL gapped_acq_cycles: got %0d required 63", c);
        end
        track_steps(48, 1, 16);
        gapped   = 1'b0;
        next_val = 1'b1;
    endtask

    task automatic test_reacq();
        int c;
        do_reset();
        peak_ph = 3; peak_i = 16'sd1000; peak_q = 16'sd1000;
        run_acq(3, c);
        track_steps(16, 3, 8);
        peak_ph = 7; peak_i = 16'sd1200; peak_q = -16'sd700;
        track_steps(16, 3, 8);
        for (int k = 0; k < 8 && tb_ph != 3; k++) step(1'b0);
        pend_reacq = 1'b1;
        step(1'b0);
        total++;
        if (lock_o !== 1'b0) begin
            bad++;
            $display("FAIL reacq_lock: lock_o=%b required 0", lock_o);
        end
        total++;
        if (sym_val_o !== 1'b1 || i_sym !== 16'sd0 || bit_i !== 1'b1) begin
            bad++;
            $display("FAIL reacq_pending: sv=%b i=%0d bi=%b required sv=1 i=0 bi=1",
                     sym_val_o, i_sym, bit_i);
        end
        run_acq(7, c);
        total++;
        if (c != 28) begin
            bad++;
            $display("FAIL reacq_acq_cycles: got %0d required 28", c);
        end
        track_steps(16, 7, 8);
    endtask

    task automatic test_reset_mid_track();
        int c;
        rst_n = 1'b0;
        #1;
        total++;
        if ({lock_o, phase_o, sym_val_o, bit_i, bit_q} !== 6'b0 || i_sym !== 16'sd0 || q_sym !== 16'sd0) begin
            bad++;
            $display("FAIL async_reset: lock=%b phase=%0d sv=%b i=%0d q=%0d required all 0",
                     lock_o, phase_o, sym_val_o, i_sym, q_sym);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (lock_o !== 1'b0 || phase_o !== 3'd0 || i_sym !== 16'sd0) begin
            bad++;
            $display("FAIL reset_held: lock=%b phase=%0d i=%0d required 0", lock_o, phase_o, i_sym);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        tb_ph    = 0;
        next_val = 1'b1;
        repeat (3) step(1'b1);
        run_acq(7, c);
        total++;
        if (c != 32) begin
            bad++;
            $display("FAIL post_reset_acq_cycles: got %0d required 32", c);
        end
        track_steps(16, 7, 8);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_tie();
        test_saturation();
        test_gapped();
        test_reacq();
        test_reset_mid_track();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/msk_sym_sampler.md
MSK_SYM_SAMPLER -- requirements
Module: msk_sym_sampler

Interface
REQ-001 Parameter SPS, default 8: samples per symbol at the input (power of 2, 2..16).
REQ-002 Parameter ACQ_SYMS, default 64: symbols integrated per phase during acquisition (power of 2, 4..256).
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port i_in / q_in  input  16 each: signed matched-filter output samples.
REQ-006 Port iq_val_i  input  1: i_in/q_in valid this cycle.
REQ-007 Port reacq_i  input  1: single-cycle pulse that restarts acquisition.
REQ-008 Port i_sym / q_sym  output  16 each: signed symbol-rate samples at the selected phase.
REQ-009 Port bit_i / bit_q  output  1 each: hard decisions; 1 when the sample is >= 0, else 0.
REQ-010 Port sym_val_o  output  1: one-cycle pulse qualifying i_sym, q_sym, bit_i and bit_q.
REQ-011 Port phase_o  output  log2(SPS): selected sampling phase.
REQ-012 Port lock_o  output  1: high while in TRACK.

Function
REQ-013 Phase counter ph: 0..SPS-1, advances by 1 on each iq_val_i=1 cycle in every state, wraps SPS-1 -> 0; no advance when iq_val_i=0.
REQ-014 States: ACQ, SEARCH, TRACK.
REQ-015 ACQ: on each valid sample, acc[ph] += mag, where mag = |i_in| + |q_in|.
REQ-016 Magnitude: |-32768| saturates to 32767; mag is 17 bits unsigned.
REQ-017 Accumulator width: 17+log2(ACQ_SYMS) bits; no overflow is possible.
REQ-018 Symbol counter increments on each valid sample with ph=SPS-1.
REQ-019 ACQ -> SEARCH on the sample that completes ACQ_SYMS symbols.
REQ-020 ACQ entry (reset or reacq) clears all acc[] and the symbol counter; ph continues counting and is not realigned.
REQ-021 SEARCH: sequential argmax scan over acc[0..SPS-1], one index per cycle, independent of iq_val_i; lasts exactly SPS cycles, then -> TRACK.
REQ-022 SEARCH tie rule: strict greater-than, so the lowest index wins; phase_o is updated on entry to TRACK.
REQ-023 Valid samples arriving during SEARCH advance ph only and produce no output.
REQ-024 TRACK: a valid sample with ph=phase_o is registered to i_sym/q_sym/bit_i/bit_q, and sym_val_o pulses on the next cycle (latency 1).
REQ-025 Outputs hold their values between pulses; sym_val_o=0 in ACQ and SEARCH.
REQ-026 reacq_i=1 in any state forces ACQ on the next cycle and drops lock_o in that cycle.
REQ-027 A sym_val_o pending from the reacq cycle's sample is still emitted.
REQ-028 reacq_i and a completing ACQ sample in the same cycle: reacq wins and acquisition restarts.
REQ-029 lock_o = (state == TRACK), registered.

Reset
REQ-030 While rst_n=0 (async assert), the following are held at 0: state=ACQ, ph, acc[], symbol counter, i_sym, q_sym, bit_i, bit_q, sym_val_o, phase_o, lock_o.
REQ-031 Deassertion is synchronised to clk; the first valid sample after release has ph=0.
REQ-032 Reset mid-TRACK or mid-SEARCH discards all state, and acquisition restarts from ACQ.

Verification
REQ-033 Impulse train, SPS=8, ACQ_SYMS=4: iq_val_i=1 continuously, i_in=q_in=1000 at ph=3, 0 elsewhere -> lock_o rises 8 cycles after the 32nd sample; phase_o=3; sym_val_o every 8 cycles, i_sym=1000, bit_i=1.
REQ-034 Tie: equal magnitude 500 at ph=2 and ph=5 -> phase_o=2.
REQ-035 Sign and saturation: peak sample i_in=-32768, q_in=-32768 at ph=6 -> phase_o=6; in TRACK i_sym=-32768, bit_i=0, bit_q=0.
REQ-036 Gapped valid (iq_val_i toggling 1,0) with peak at ph=1 -> phase_o=1; sym_val_o spacing 16 cycles; acquisition takes twice as many cycles.
REQ-037 Peak moved from ph=3 to ph=7 mid-TRACK, then reacq_i pulse -> lock_o low the next cycle; after re-acquisition phase_o=7; no sym_val_o during ACQ or SEARCH.
REQ-038 rst_n pulled low mid-TRACK for 3 cycles -> all outputs 0 immediately (asynchronous); after release, full acquisition repeats and yields the same phase_o.
